// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared state type and queue-entry widths for the fetch front end
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2,
    ST_HALT = 2'd3
  } fetch_state_e;

  localparam int DEF_ADDR_W  = 16;
  localparam int DEF_INSTR_W = 16;
  localparam int DEF_ENTRY_W = DEF_INSTR_W + DEF_ADDR_W;

  // Queue entry is {instr, pc}, instruction in the upper bits.
  function automatic int entry_w(input int instr_w, input int addr_w);
    return instr_w + addr_w;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - DEPTH-entry circular prefetch queue with push, pop, flush and occupancy count
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  input  logic                     flush,
  output logic [W-1:0]             rdata,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign valid = (count_q != '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign count = count_q;
  // Head reads as zero when empty so the decoder side never sees stale entries.
  assign rdata = valid ? mem_q[rd_ptr_q] : '0;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_push  = push && !flush && (!full || pop);
    do_pop   = pop && !flush && valid;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - decoupled instruction fetch: PC, single-outstanding imem request FSM, prefetch queue
// FETCH_BYPASS_EN: present a response straight to the decoder when the queue is empty.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                INSTR_W  = DEF_INSTR_W,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                PC_STEP  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_data,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               instr_ready,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               halt_req,
  output logic               halted
);

  localparam int ENTRY_W = entry_w(INSTR_W, ADDR_W);
  localparam int CNT_W   = $clog2(DEPTH) + 1;

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0]  req_pc_q, req_pc_d;
  logic               issue;
  logic               take_ack;
  logic               queue_full;
  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_valid;
  logic [ENTRY_W-1:0] fifo_wdata;
  logic [ENTRY_W-1:0] fifo_rdata;
  logic [CNT_W-1:0]   fifo_count;

  assign queue_full = (fifo_count == CNT_W'(DEPTH));
  assign issue      = (state_q == ST_IDLE) && !queue_full && !halt_req && !redirect;
  // Held low while in reset so memory never sees a request from a resetting core.
  assign imem_req   = issue && rst_n;
  assign imem_addr  = fetch_pc_q;
  assign halted     = (state_q == ST_HALT);

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    take_ack   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (halt_req && !redirect) begin
          state_d = ST_HALT;
        end else if (issue) begin
          state_d    = ST_WAIT;
          req_pc_d   = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + ADDR_W'(PC_STEP);
        end
      end
      ST_WAIT: begin
        if (imem_ack) begin
          take_ack = !redirect;
          state_d  = (!redirect && halt_req) ? ST_HALT : ST_IDLE;
        end else if (redirect) begin
          state_d = ST_DROP;
        end
      end
      ST_DROP: begin
        if (imem_ack) begin
          state_d = (!redirect && halt_req) ? ST_HALT : ST_IDLE;
        end
      end
      ST_HALT: begin
        if (!halt_req) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (redirect) begin
      fetch_pc_d = redirect_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
    end
  end

  assign fifo_wdata = {imem_data, req_pc_q};
  // A pop coinciding with a redirect is meaningless: the flush discards the head anyway.
  assign fifo_pop   = fifo_valid && instr_ready && !redirect;

`ifdef FETCH_BYPASS_EN
  logic bypass;
  assign bypass    = take_ack && !fifo_valid;
  assign fifo_push = take_ack && !(bypass && instr_ready);
`else
  assign fifo_push = take_ack;
`endif

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .flush (redirect),
    .rdata (fifo_rdata),
    .valid (fifo_valid),
    .count (fifo_count)
  );

  always_comb begin
    instr_valid = fifo_valid;
    instr       = fifo_rdata[ENTRY_W-1 -: INSTR_W];
    instr_pc    = fifo_rdata[ADDR_W-1:0];
`ifdef FETCH_BYPASS_EN
    if (bypass) begin
      instr_valid = 1'b1;
      instr       = imem_data;
      instr_pc    = req_pc_q;
    end
`endif
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit with a latency-configurable instruction memory model
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_data = 16'h0000;
  logic        instr_valid;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        halt_req = 1'b0;
  logic        halted;

  fetch_unit #(
    .ADDR_W   (16),
    .INSTR_W  (16),
    .DEPTH    (4),
    .RESET_PC (16'h0000),
    .PC_STEP  (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_data   (imem_data),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt_req    (halt_req),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] ins;
    logic [15:0] pc;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          mem_lat = 1;
  logic        pend = 1'b0;
  logic [15:0] pend_addr = 16'h0000;
  int          lat_cnt = 0;
  logic [15:0] poison_addr = 16'hFFFF;
  logic [15:0] req_a[$];
  int          req_c[$];
  logic [15:0] ea[$];
  int          ec[$];
  bit          dead_seen = 1'b0;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return a ^ 16'h3C00;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic expect_item(input logic [15:0] pc, input int c);
    exp_q.push_back('{ins: mem_word(pc), pc: pc, cyc: c});
  endtask

  task automatic check_reqs(input string tag);
    chk({tag, "_req_count"}, req_a.size(), ea.size());
    for (int i = 0; i < ea.size() && i < req_a.size(); i++) begin
      chk({tag, "_req_addr"}, {16'h0, req_a[i]}, {16'h0, ea[i]});
      chk({tag, "_req_cyc"}, req_c[i], ec[i]);
    end
  endtask

  // Cycle 0 is the cycle in which rst_n is released.
  always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

  // Memory: a request seen in cycle c is acknowledged in cycle c+mem_lat.
  initial forever begin
    @(negedge clk);
    if (rst_n && imem_req) begin
      pend      = 1'b1;
      pend_addr = imem_addr;
      lat_cnt   = mem_lat;
      req_a.push_back(imem_addr);
      req_c.push_back(cyc);
    end
    @(posedge clk);
    #1;
    imem_ack = 1'b0;
    if (!rst_n) begin
      pend = 1'b0;
    end else if (pend) begin
      if (lat_cnt <= 1) begin
        imem_ack  = 1'b1;
        imem_data = (pend_addr == poison_addr) ? 16'hDEAD : mem_word(pend_addr);
        pend      = 1'b0;
      end else begin
        lat_cnt--;
      end
    end
  end

  // Monitor: every consumed head is checked against the oldest expectation.
  always @(negedge clk) begin
    if (instr_valid && instr == 16'hDEAD) dead_seen = 1'b1;
    if (rst_n && instr_valid && instr_ready && !redirect) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_instr: got pc %0h instr %0h expected nothing at cycle %0d", instr_pc, instr, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("head_instr", {16'h0, instr}, {16'h0, mon_e.ins});
        chk("head_pc", {16'h0, instr_pc}, {16'h0, mon_e.pc});
        if (mon_e.cyc >= 0) chk("head_cycle", cyc, mon_e.cyc);
      end
    end
  end

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic at_neg(input int n);
    wait_cyc(n);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    instr_ready = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 16'h0000;
    halt_req    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete();
    req_a.delete();
    req_c.delete();
    poison_addr = 16'hFFFF;
    rst_n = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_imem_req"}, imem_req, 0);
    chk({tag, "_imem_addr"}, imem_addr, 16'h0000);
    chk({tag, "_instr_valid"}, instr_valid, 0);
    chk({tag, "_instr"}, instr, 0);
    chk({tag, "_instr_pc"}, instr_pc, 0);
    chk({tag, "_halted"}, halted, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");

    // Sequential fetch, L=1: requests every other cycle, heads two cycles later
    mem_lat = 1;
    do_reset();
    instr_ready = 1'b1;
    expect_item(16'h0000, 2);
    expect_item(16'h0002, 4);
    expect_item(16'h0004, 6);
    expect_item(16'h0006, 8);
    wait_cyc(7);
    halt_req = 1'b1;
    at_neg(8);
    chk("seq_halted", halted, 1);
    wait_cyc(11);
    ea = '{16'h0000, 16'h0002, 16'h0004, 16'h0006};
    ec = '{0, 2, 4, 6};
    check_reqs("seq");
    chk("seq_drained", exp_q.size(), 0);

    // Back-pressure: queue fills at DEPTH, one pop frees one request
    mem_lat = 1;
    do_reset();
    wait_cyc(15);
    chk("full_req_count", req_a.size(), 4);
    chk("full_instr_valid", instr_valid, 1);
    expect_item(16'h0000, 15);
    instr_ready = 1'b1;
    wait_cyc(16);
    instr_ready = 1'b0;
    wait_cyc(20);
    ea = '{16'h0000, 16'h0002, 16'h0004, 16'h0006, 16'h0008};
    ec = '{0, 2, 4, 6, 16};
    check_reqs("full");
    expect_item(16'h0002, 20);
    expect_item(16'h0004, 21);
    expect_item(16'h0006, 22);
    expect_item(16'h0008, 23);
    halt_req    = 1'b1;
    instr_ready = 1'b1;
    wait_cyc(26);
    chk("full_drained", exp_q.size(), 0);
    chk("full_req_after", req_a.size(), 5);

    // Redirect while waiting: in-flight 0xDEAD response is dropped
    mem_lat = 2;
    do_reset();
    poison_addr = 16'h0004;
    wait_cyc(7);
    redirect    = 1'b1;
    redirect_pc = 16'h0100;
    wait_cyc(8);
    redirect = 1'b0;
    at_neg(8);
    chk("redir_queue_empty", instr_valid, 0);
    wait_cyc(9);
    instr_ready = 1'b1;
    expect_item(16'h0100, 12);
    wait_cyc(12);
    halt_req = 1'b1;
    wait_cyc(15);
    ea = '{16'h0000, 16'h0002, 16'h0004, 16'h0100};
    ec = '{0, 3, 6, 9};
    check_reqs("redir");
    chk("redir_no_dead", dead_seen, 0);
    chk("redir_drained", exp_q.size(), 0);

    // Redirect coincident with ack and pop
    mem_lat = 1;
    do_reset();
    wait_cyc(5);
    redirect    = 1'b1;
    redirect_pc = 16'h0200;
    instr_ready = 1'b1;
    wait_cyc(6);
    redirect = 1'b0;
    expect_item(16'h0200, 8);
    at_neg(6);
    chk("coinc_queue_empty", instr_valid, 0);
    wait_cyc(8);
    halt_req = 1'b1;
    wait_cyc(11);
    ea = '{16'h0000, 16'h0002, 16'h0004, 16'h0200};
    ec = '{0, 2, 4, 6};
    check_reqs("coinc");
    chk("coinc_drained", exp_q.size(), 0);

    // Halt during WAIT, then release resumes at the next sequential PC
    mem_lat = 2;
    do_reset();
    instr_ready = 1'b1;
    expect_item(16'h0000, 3);
    expect_item(16'h0002, 6);
    expect_item(16'h0004, 16);
    wait_cyc(4);
    halt_req = 1'b1;
    at_neg(5);
    chk("halt_before_ack", halted, 0);
    at_neg(6);
    chk("halt_after_ack", halted, 1);
    wait_cyc(12);
    chk("halt_no_req", req_a.size(), 2);
    halt_req = 1'b0;
    wait_cyc(14);
    halt_req = 1'b1;
    wait_cyc(19);
    ea = '{16'h0000, 16'h0002, 16'h0004};
    ec = '{0, 3, 13};
    check_reqs("halt");
    chk("halt_drained", exp_q.size(), 0);

    // PC wrap at 0xFFFE, redirect in cycle 0 gives a request in cycle 1
    mem_lat = 1;
    do_reset();
    redirect    = 1'b1;
    redirect_pc = 16'hFFFE;
    instr_ready = 1'b1;
    expect_item(16'hFFFE, 3);
    expect_item(16'h0000, 5);
    wait_cyc(1);
    redirect = 1'b0;
    wait_cyc(4);
    halt_req = 1'b1;
    wait_cyc(8);
    ea = '{16'hFFFE, 16'h0000};
    ec = '{1, 3};
    check_reqs("wrap");
    chk("wrap_drained", exp_q.size(), 0);

    // Asynchronous reset mid-WAIT with a non-empty queue
    mem_lat = 2;
    do_reset();
    wait_cyc(4);
    #3;
    chk("areset_pre_valid", instr_valid, 1);
    chk("areset_pre_addr", imem_addr, 16'h0004);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("areset");
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
